// File: rtl/chop_clock_sequencer_if.sv
// Config port, run control and chopper clock outputs of the chopper clock sequencer.
// The master side drives config and run requests; the slave side drives the clocks and status.
interface chop_clock_sequencer_if #(
   parameter int unsigned NCH  = 16,
   parameter int unsigned DIVW = 12
);
   logic            cfg_we;
   logic [3:0]      cfg_addr;
   logic [DIVW-1:0] cfg_data;
   logic            cfg_err;
   logic            start;
   logic            stop;
   logic            busy;
   logic            running;
   logic [NCH-1:0]  chop;
   logic [NCH-1:0]  chopb;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start, stop,
      input  cfg_err, busy, running, chop, chopb
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start, stop,
      output cfg_err, busy, running, chop, chopb
   );
endinterface

// File: rtl/chop_clock_sequencer.sv
// Per-channel chopper clock generator with staggered channel ramp-up and reverse ramp-down.
// Half-period dividers are writable only while idle.
module chop_clock_sequencer #(
   parameter int unsigned NCH      = 16,
   parameter int unsigned DIVW     = 12,
   parameter int unsigned DEF_HALF = 64,
   parameter int unsigned STAGGER  = 8
) (
   input logic clk,
   input logic rst_n,
   chop_clock_sequencer_if.slave bus
);
   localparam int unsigned IW = 4;
   localparam int unsigned SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

   typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx, idx_nxt;
   logic [SW-1:0]   stg, stg_nxt;
   logic [NCH-1:0]  en_set, en_clr;
   logic [NCH-1:0]  en;
   logic [NCH-1:0]  chop_q, chopb_q;
   logic [DIVW-1:0] cnt  [NCH];
   logic [DIVW-1:0] half [NCH];
   logic            busy_q, running_q, cfg_err_q;
   logic            cfg_ok_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         stg   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         stg   <= stg_nxt;
      end
   end

   // idx is the next channel to enable on the way up, the next to disable on the way down
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      stg_nxt   = stg;
      en_set    = '0;
      en_clr    = '0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_nxt = RAMP_UP;
               idx_nxt   = '0;
               stg_nxt   = '0;
            end
         end
         RAMP_UP: begin
            if (bus.stop) begin
               if (idx == '0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RAMP_DOWN;
                  idx_nxt   = idx - IW'(1);
                  stg_nxt   = '0;
               end
            end else if (stg == '0) begin
               for (int i = 0; i < int'(NCH); i++) begin
                  en_set[i] = (idx == IW'(i));
               end
               if (idx == IW'(NCH - 1)) begin
                  state_nxt = RUN;
               end else begin
                  idx_nxt = idx + IW'(1);
                  stg_nxt = SW'(STAGGER - 1);
               end
            end else begin
               stg_nxt = stg - SW'(1);
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_nxt = RAMP_DOWN;
               idx_nxt   = IW'(NCH - 1);
               stg_nxt   = '0;
            end
         end
         RAMP_DOWN: begin
            if (stg == '0) begin
               for (int i = 0; i < int'(NCH); i++) begin
                  en_clr[i] = (idx == IW'(i));
               end
               if (idx == '0) begin
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx - IW'(1);
                  stg_nxt = SW'(STAGGER - 1);
               end
            end else begin
               stg_nxt = stg - SW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         busy_q    <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
         running_q <= (state_nxt == RUN);
      end
   end

   assign cfg_ok_c = bus.cfg_we && (state == IDLE) &&
                     ({1'b0, bus.cfg_addr} < 5'(NCH)) && (bus.cfg_data != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
         for (int i = 0; i < int'(NCH); i++) begin
            half[i] <= DIVW'(DEF_HALF);
         end
      end else begin
         cfg_err_q <= bus.cfg_we && !cfg_ok_c;
         for (int i = 0; i < int'(NCH); i++) begin
            if (cfg_ok_c && (bus.cfg_addr == IW'(i))) begin
               half[i] <= bus.cfg_data;
            end
         end
      end
   end

   // Enable starts a full-length high phase; disable opens both switches at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en      <= '0;
         chop_q  <= '0;
         chopb_q <= '0;
         for (int i = 0; i < int'(NCH); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NCH); i++) begin
            if (en_clr[i]) begin
               en[i]      <= 1'b0;
               chop_q[i]  <= 1'b0;
               chopb_q[i] <= 1'b0;
               cnt[i]     <= '0;
            end else if (en_set[i]) begin
               en[i]      <= 1'b1;
               chop_q[i]  <= 1'b1;
               chopb_q[i] <= 1'b0;
               cnt[i]     <= '0;
            end else if (en[i]) begin
               if (cnt[i] == half[i] - DIVW'(1)) begin
                  chop_q[i]  <= ~chop_q[i];
                  chopb_q[i] <= chop_q[i];
                  cnt[i]     <= '0;
               end else begin
                  cnt[i] <= cnt[i] + DIVW'(1);
               end
            end
         end
      end
   end

   assign bus.chop    = chop_q;
   assign bus.chopb   = chopb_q;
   assign bus.busy    = busy_q;
   assign bus.running = running_q;
   assign bus.cfg_err = cfg_err_q;

   // Both switches of a pair must never be closed together
   a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) (chop_q & chopb_q) == '0);
   a_status_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && running_q));
endmodule

// File: tb/tb_chop_clock_sequencer.sv
// Self-checking bench for chop_clock_sequencer: a closed-form waveform model feeds a
// per-edge scoreboard, with point checks on ramp edges, config rejects and reset.
module tb_chop_clock_sequencer;
   localparam int unsigned NCH  = 16;
   localparam int unsigned DIVW = 12;
   localparam int          STG  = 8;
   localparam int          NEVER = 1 << 29;

   typedef struct {
      int             t;
      logic [NCH-1:0] chop;
      logic [NCH-1:0] chopb;
      logic           busy;
      logic           running;
      logic           err;
   } exp_t;

   typedef struct {
      logic            we;
      logic [3:0]      addr;
      logic [DIVW-1:0] data;
      logic            start;
      logic            stop;
      logic            err;
   } row_t;

   logic clk;
   logic rst_n;

   chop_clock_sequencer_if #(.NCH(NCH), .DIVW(DIVW)) bus ();
   chop_clock_sequencer_if #(.NCH(8), .DIVW(DIVW)) bus2 ();

   chop_clock_sequencer #(.NCH(NCH), .DIVW(DIVW), .DEF_HALF(64), .STAGGER(STG)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   chop_clock_sequencer #(.NCH(8), .DIVW(DIVW), .DEF_HALF(3), .STAGGER(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   exp_t q[$];
   row_t tbl[9];

   int en_e[NCH], dis_e[NCH], half_m[NCH];
   int ramp_e, run_e, down_e, idle_e;
   int rise_e[NCH], off_e[NCH];
   int run_rise, busy_fall;
   logic [NCH-1:0] prev_chop, prev_act;
   logic prev_run, prev_busy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic void model_idle();
      ramp_e = NEVER; run_e = NEVER; down_e = NEVER; idle_e = NEVER;
      for (int i = 0; i < int'(NCH); i++) begin
         en_e[i]  = NEVER;
         dis_e[i] = NEVER;
      end
   endfunction

   // Event schedule for START sampled at edge k and STOP sampled at edge s
   function automatic void plan(input int k, input int s);
      int n;
      ramp_e = k; run_e = NEVER; down_e = s;
      for (int i = 0; i < int'(NCH); i++) begin
         en_e[i]  = k + 1 + i * STG;
         dis_e[i] = NEVER;
      end
      if (s <= en_e[NCH-1]) begin
         n = 0;
         for (int i = 0; i < int'(NCH); i++) if (en_e[i] < s) n++;
         for (int i = 0; i < int'(NCH); i++) begin
            if (i >= n) en_e[i] = NEVER;
            else        dis_e[i] = s + 1 + (n - 1 - i) * STG;
         end
         idle_e = (n == 0) ? s : dis_e[0];
      end else begin
         run_e = en_e[NCH-1];
         for (int i = 0; i < int'(NCH); i++) dis_e[i] = s + 1 + (int'(NCH) - 1 - i) * STG;
         idle_e = dis_e[0];
      end
   endfunction

   function automatic exp_t model(input int t, input logic err);
      exp_t x;
      x.t = t; x.chop = '0; x.chopb = '0; x.err = err;
      for (int i = 0; i < int'(NCH); i++) begin
         if (t >= en_e[i] && t < dis_e[i]) begin
            x.chop[i]  = (((t - en_e[i]) / half_m[i]) % 2) == 0;
            x.chopb[i] = !x.chop[i];
         end
      end
      x.running = (t >= run_e) && (t < down_e);
      x.busy    = (t >= ramp_e) && (t < idle_e) && !x.running;
      return x;
   endfunction

   function automatic void clear_marks();
      run_rise = NEVER; busy_fall = NEVER;
      for (int i = 0; i < int'(NCH); i++) begin
         rise_e[i] = NEVER;
         off_e[i]  = NEVER;
      end
   endfunction

   // One master edge: expectation queued before the edge, compared at the following negedge
   task automatic step(input logic exp_err);
      exp_t x, y;
      logic [NCH-1:0] act;
      edge_n++;
      x = model(edge_n, exp_err);
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
      y = q.pop_front();
      check($sformatf("outputs@%0d", y.t),
            64'({bus.chop, bus.chopb, bus.busy, bus.running, bus.cfg_err}),
            64'({y.chop, y.chopb, y.busy, y.running, y.err}));
      act = bus.chop | bus.chopb;
      for (int i = 0; i < int'(NCH); i++) begin
         if (bus.chop[i] && !prev_chop[i] && rise_e[i] == NEVER) rise_e[i] = y.t;
         if (!act[i] && prev_act[i]) off_e[i] = y.t;
      end
      if (bus.running && !prev_run && run_rise == NEVER) run_rise = y.t;
      if (!bus.busy && prev_busy) busy_fall = y.t;
      prev_chop = bus.chop; prev_act = act; prev_run = bus.running; prev_busy = bus.busy;
   endtask

   task automatic clear_inputs();
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.start = 1'b0; bus.stop = 1'b0;
      bus2.cfg_we = 1'b0; bus2.cfg_addr = '0; bus2.cfg_data = '0; bus2.start = 1'b0; bus2.stop = 1'b0;
   endtask

   initial begin
      int k, s;
      tbl[0] = '{1'b1, 4'd3,  12'd5, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 4'd4,  12'd7, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 4'd2,  12'd0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 4'd0,  12'd0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 4'd0,  12'd0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 4'd15, 12'd0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 4'd0,  12'd0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 4'd6,  12'd0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 4'd0,  12'd0, 1'b0, 1'b0, 1'b0};

      clear_inputs();
      model_idle();
      clear_marks();
      for (int i = 0; i < int'(NCH); i++) half_m[i] = 64;
      prev_chop = '0; prev_act = '0; prev_run = 1'b0; prev_busy = 1'b0;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_chop",  64'(bus.chop),  64'(0));
      check("reset_chopb", 64'(bus.chopb), 64'(0));
      check("reset_status", 64'({bus.busy, bus.running, bus.cfg_err}), 64'(0));
      step(1'b0);
      step(1'b0);
      rst_n = 1'b1;
      step(1'b0);

      // Config writes and idle-state requests from the table
      for (int j = 0; j < 9; j++) begin
         bus.cfg_we = tbl[j].we; bus.cfg_addr = tbl[j].addr; bus.cfg_data = tbl[j].data;
         bus.start = tbl[j].start; bus.stop = tbl[j].stop;
         if (tbl[j].we && !tbl[j].err) half_m[int'(tbl[j].addr)] = int'(tbl[j].data);
         step(tbl[j].err);
      end
      clear_inputs();

      // Address range on the 8-channel instance
      bus2.cfg_we = 1'b1; bus2.cfg_addr = 4'd15; bus2.cfg_data = 12'd5;
      step(1'b0);
      check("err8_addr15", 64'(bus2.cfg_err), 64'(1));
      bus2.cfg_addr = 4'd7;
      step(1'b0);
      check("err8_addr7", 64'(bus2.cfg_err), 64'(0));
      bus2.cfg_addr = 4'd8;
      step(1'b0);
      check("err8_addr8", 64'(bus2.cfg_err), 64'(1));
      bus2.cfg_we = 1'b0;
      step(1'b0);
      check("err8_pulse_end", 64'(bus2.cfg_err), 64'(0));

      // Full ramp with START held through RUN and a rejected write in RUN
      clear_marks();
      k = edge_n + 1; s = k + 190;
      plan(k, s);
      for (int t = k; t <= s + 130; t++) begin
         bus.start = (t < k + 150); bus.stop = (t == s);
         bus.cfg_we = (t == k + 140); bus.cfg_addr = 4'd3; bus.cfg_data = 12'd9;
         step(t == k + 140);
      end
      clear_inputs();
      check("s1_ch0_rise",  64'(rise_e[0]  - k), 64'(1));
      check("s1_ch5_rise",  64'(rise_e[5]  - k), 64'(41));
      check("s1_ch15_rise", 64'(rise_e[15] - k), 64'(121));
      check("s1_run_rise",  64'(run_rise   - k), 64'(121));
      check("s1_ch15_off",  64'(off_e[15]  - s), 64'(1));
      check("s1_ch14_off",  64'(off_e[14]  - s), 64'(9));
      check("s1_ch0_off",   64'(off_e[0]   - s), 64'(121));
      check("s1_idle",      64'(busy_fall  - s), 64'(121));

      // Stop during ramp-up, with a same-cycle write to channel 0
      clear_marks();
      k = edge_n + 1; s = k + 20;
      half_m[0] = 3;
      plan(k, s);
      for (int t = k; t <= s + 30; t++) begin
         bus.start = (t == k); bus.stop = (t == s);
         bus.cfg_we = (t == k); bus.cfg_addr = 4'd0; bus.cfg_data = 12'd3;
         step(1'b0);
      end
      clear_inputs();
      check("s2_ch2_rise", 64'(rise_e[2] - k), 64'(17));
      check("s2_ch2_off",  64'(off_e[2]  - k), 64'(21));
      check("s2_ch1_off",  64'(off_e[1]  - k), 64'(29));
      check("s2_ch0_off",  64'(off_e[0]  - k), 64'(37));
      check("s2_ch3_none", 64'(rise_e[3] == NEVER), 64'(1));
      check("s2_idle",     64'(busy_fall - k), 64'(37));

      // Asynchronous reset in the middle of a ramp
      k = edge_n + 1;
      plan(k, NEVER);
      for (int t = k; t < k + 70; t++) begin
         bus.start = (t == k);
         step(1'b0);
      end
      clear_inputs();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_chop",  64'(bus.chop),  64'(0));
      check("midrst_chopb", 64'(bus.chopb), 64'(0));
      check("midrst_busy",  64'(bus.busy),  64'(0));
      check("midrst_run",   64'(bus.running), 64'(0));
      model_idle();
      for (int i = 0; i < int'(NCH); i++) half_m[i] = 64;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      rst_n = 1'b1;
      step(1'b0);

      // Defaults restored: every channel at 128-cycle period
      clear_marks();
      k = edge_n + 1; s = k + 121 + 260;
      plan(k, s);
      for (int t = k; t <= s + 125; t++) begin
         bus.start = (t == k); bus.stop = (t == s);
         step(1'b0);
      end
      clear_inputs();
      check("s4_ch15_rise", 64'(rise_e[15] - k), 64'(121));
      check("s4_ch0_off",   64'(off_e[0]   - s), 64'(121));
      check("s4_idle",      64'(busy_fall  - s), 64'(121));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/chop_clock_sequencer.md
Name: chop_clock_sequencer

Overview:
- Synthesizable controller for the 16-channel chopper clock set of the multi-channel EMG front end.
- Derives one chopper clock pair per channel from a single master clock using per-channel programmable half-period dividers.
- Enables channels in a staggered ramp on start and disables them in reverse order on stop, so that channel switching transients do not coincide.
- Divider configuration is written through a simple register port while idle.

Parameters:
- NCH, 16: number of channels (2..16).
- DIVW, 12: half-period counter/register width.
- DEF_HALF, 64: reset value of every channel half-period register, in master cycles.
- STAGGER, 8: master cycles between consecutive channel enables/disables (>=1).

Ports:
- CLK  in  1  master clock.
- RSTB  in  1  asynchronous active-low reset.
- CFG_WE  in  1  config write strobe, one cycle.
- CFG_ADDR  in  4  channel index for write.
- CFG_DATA  in  DIVW  half-period in master cycles.
- CFG_ERR  out  1  one-cycle pulse: write rejected.
- START  in  1  level sampled each cycle; request ramp-up.
- STOP  in  1  level sampled each cycle; request ramp-down.
- BUSY  out  1  high in RAMP_UP or RAMP_DOWN.
- RUNNING  out  1  high in RUN.
- CHOP  out  NCH  chopper clocks, registered.
- CHOPB  out  NCH  complementary chopper clocks, registered.

Behaviour:
- Reset (RSTB=0, async): state IDLE; all half registers = DEF_HALF; all channels disabled; CHOP=0, CHOPB=0, CFG_ERR=0, BUSY=0, RUNNING=0.
- Disabled channel: CHOP[i]=0 and CHOPB[i]=0 (both switches open). Enabled channel: CHOPB[i]=~CHOP[i] every cycle.
- Channel enable at edge e: CHOP[i]=1 and cnt[i]=0 at e.
- Each later edge: if cnt[i]==half[i]-1, toggle CHOP[i] and clear cnt[i]; otherwise increment cnt[i].
- Result: period 2*half[i] cycles, exactly 50% duty, first high phase full length.
- Disable at edge d: CHOP[i]=CHOPB[i]=0 immediately at d and cnt cleared. No wait for phase.

FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN.
- IDLE:
  - START=1 and STOP=0 at edge k: RAMP_UP.
  - Channel i is enabled at edge k+1+i*STAGGER.
  - The edge that enables channel NCH-1 also moves the state to RUN.
- RUN: STOP=1 moves to RAMP_DOWN.
- RAMP_DOWN, entered at edge k from RUN or RAMP_UP:
  - The highest-index enabled channel is disabled at edge k+1.
  - Each next lower channel is disabled every STAGGER cycles after that.
  - The edge disabling channel 0 moves the state to IDLE.
- STOP during RAMP_UP: enabling ceases immediately; ramp-down starts from the highest currently enabled channel. If no channel is enabled yet, go to IDLE at k+1.
- START and STOP together: STOP wins.
- START outside IDLE: ignored. STOP in IDLE or RAMP_DOWN: ignored.
- BUSY and RUNNING are registered and decoded from the state in the same cycle as the state.

Config writes:
- Accepted only when state==IDLE, CFG_ADDR<NCH and CFG_DATA!=0; half[CFG_ADDR] updates at that edge.
- Any other CFG_WE sets CFG_ERR=1 for exactly the next cycle and leaves registers unchanged.
- A write in the same cycle that START is sampled in IDLE is accepted and used by the ramp.
- START asserted in the cycle after a write sees the new value.

Test Plan:
- Reset defaults: RSTB low mid-run for 3 cycles -> CHOP=CHOPB=0 asynchronously, BUSY=RUNNING=0. After reset, START -> every channel period 128 cycles, high 64.
- Ramp timing: STAGGER=8, START at edge 10 -> CH0 rises at 11, CH5 at 51, CH15 at 131, RUNNING=1 from edge 131. STOP at 200 -> CH15 off at 201, CH14 at 209, CH0 at 321, IDLE at 321.
- Config: write ch3=5, ch4=7 in IDLE, then START -> CH3 period 10 (5 high/5 low), CH4 period 14, CHOPB exact complement.
- Rejects: CFG_WE in RUN, CFG_DATA=0 in IDLE, and CFG_ADDR=15 with NCH=8 -> CFG_ERR one-cycle pulse each; periods unchanged.
- STOP during ramp: START at 0, STOP at 20 (CH0–CH2 enabled) -> CH2 off at 21, CH1 at 29, CH0 at 37, CH3+ never rise.
- Simultaneous START+STOP in IDLE -> stays IDLE, no CHOP activity. START held high in RUN -> no restart.
